// File: rtl/arb_defs.sv
// Shared definitions for the data-memory arbiter: owner encoding and the
// default starvation limit.
package arb_defs;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DSP  = 2'd2;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the display lost the port to the CPU.
module starve_counter #(
    parameter int MAXV    = 4,
    parameter int CNTBITS = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_max
);

    localparam logic [CNTBITS-1:0] MAXC = CNTBITS'(MAXV);

    logic [CNTBITS-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr)
            r_cnt <= '0;
        else if (i_inc && r_cnt != MAXC)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_at_max = (r_cnt == MAXC);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmemory port between the MIPS data port (fixed priority)
// and the display-scan read port, with a forced display grant on starvation.
module dmem_arbiter
    import arb_defs::*;
#(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNTBITS    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cpu_memread,
    input  logic             i_cpu_memwrite,
    input  logic [WIDTH-1:0] i_cpu_adr,
    input  logic [WIDTH-1:0] i_cpu_writedata,
    output logic [WIDTH-1:0] o_cpu_memdata,
    output logic             o_cpu_stall,
    input  logic             i_dsp_req,
    input  logic [WIDTH-1:0] i_dsp_adr,
    output logic             o_dsp_gnt,
    output logic             o_dsp_valid,
    output logic [WIDTH-1:0] o_dsp_rdata,
    output logic             o_mem_memwrite,
    output logic [WIDTH-1:0] o_mem_adr,
    output logic [WIDTH-1:0] o_mem_writedata,
    input  logic [WIDTH-1:0] i_mem_memdata
);

    logic             w_cpu_act;
    logic             w_at_max;
    logic [1:0]       w_owner;
    logic             r_dsp_valid;
    logic [WIDTH-1:0] r_dsp_rdata;

    assign w_cpu_act = i_cpu_memread | i_cpu_memwrite;

    // The display only beats an active CPU once it has lost STARVE_MAX times in a row.
    always_comb begin
        w_owner = OWN_NONE;
        if (!i_reset) begin
            if (i_dsp_req && (!w_cpu_act || w_at_max))
                w_owner = OWN_DSP;
            else if (w_cpu_act)
                w_owner = OWN_CPU;
        end
    end

    starve_counter #(
        .MAXV    (STARVE_MAX),
        .CNTBITS (CNTBITS)
    ) u_starve (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clr    ((w_owner == OWN_DSP) || !i_dsp_req),
        .i_inc    (i_dsp_req && (w_owner == OWN_CPU)),
        .o_at_max (w_at_max)
    );

    always_comb begin
        o_mem_adr      = '0;
        o_mem_memwrite = 1'b0;
        case (w_owner)
            OWN_CPU: begin
                o_mem_adr      = i_cpu_adr;
                o_mem_memwrite = i_cpu_memwrite;
            end
            OWN_DSP: o_mem_adr = i_dsp_adr;
            default: ;
        endcase
    end

    assign o_mem_writedata = (w_owner == OWN_DSP) ? '0 : i_cpu_writedata;
    assign o_cpu_memdata   = i_mem_memdata;
    assign o_dsp_gnt       = (w_owner == OWN_DSP);
    assign o_cpu_stall     = o_dsp_gnt && w_cpu_act;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dsp_valid <= 1'b0;
            r_dsp_rdata <= '0;
        end else begin
            r_dsp_valid <= o_dsp_gnt;
            if (o_dsp_gnt)
                r_dsp_rdata <= i_mem_memdata;
        end
    end

    assign o_dsp_valid = r_dsp_valid;
    assign o_dsp_rdata = r_dsp_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the MIPS core data port (memread/memwrite/adr/writedata) and a display-scan read port that fetches values for the 7-segment output.
- The CPU has fixed priority. A starvation counter forces a display grant after STARVE_MAX consecutive lost cycles; during that grant the CPU is stalled.
- Sits between mips and dmemory at the top level.
- dmemory read is combinational on address; its write is committed at the clk rising edge.

Parameters:
- WIDTH, 32, data and address width.
- STARVE_MAX, 4, consecutive contended cycles the display may lose before a forced grant (legal range 1..15).
- CNTBITS, 4, width of the starvation counter; must hold STARVE_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_memread  in  1  CPU read request.
- cpu_memwrite  in  1  CPU write request.
- cpu_adr  in  WIDTH  CPU byte address.
- cpu_writedata  in  WIDTH  CPU write data.
- cpu_memdata  out  WIDTH  read data returned to the CPU.
- cpu_stall  out  1  CPU must hold its request and not advance.
- dsp_req  in  1  display read request; held high until dsp_gnt.
- dsp_adr  in  WIDTH  display read address; stable while dsp_req is high.
- dsp_gnt  out  1  one-cycle pulse: display owns the port this cycle.
- dsp_valid  out  1  one-cycle pulse, one cycle after dsp_gnt.
- dsp_rdata  out  WIDTH  registered display read data; held between valids.
- mem_memwrite  out  1  write enable to dmemory.
- mem_adr  out  WIDTH  address to dmemory.
- mem_writedata  out  WIDTH  write data to dmemory.
- mem_memdata  in  WIDTH  combinational read data from dmemory.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high. While reset is high:
  - starve_cnt=0, dsp_valid=0, dsp_rdata=0, owner forced to NONE.
  - Therefore dsp_gnt=0, cpu_stall=0, mem_memwrite=0, mem_adr=0.
- cpu_act = cpu_memread | cpu_memwrite. If both are high, the access is a write.
- Owner is decided combinationally each cycle from the requests and the registered starve_cnt:
  - NONE: no requests.
  - CPU: cpu_act && !dsp_req.
  - CPU: cpu_act && dsp_req && starve_cnt < STARVE_MAX.
  - DSP: dsp_req && !cpu_act.
  - DSP: cpu_act && dsp_req && starve_cnt == STARVE_MAX. In this case cpu_stall=1.
- Mux outputs:
  - Owner CPU: mem_adr=cpu_adr, mem_writedata=cpu_writedata, mem_memwrite=cpu_memwrite.
  - Owner DSP: mem_adr=dsp_adr, mem_memwrite=0.
  - Owner NONE: mem_adr=0, mem_memwrite=0.
  - mem_writedata=cpu_writedata whenever owner is not DSP; it is 0 when owner is DSP.
- cpu_memdata = mem_memdata, combinational. It is meaningful only when owner=CPU and !cpu_stall.
- cpu_stall is high only in the forced-DSP cycle.
- dsp_gnt = (owner==DSP).
- Registered updates at each clk edge:
  - dsp_valid <= dsp_gnt.
  - If dsp_gnt: dsp_rdata <= mem_memdata.
- starve_cnt update, in priority order:
  - Owner is DSP, or dsp_req is low: starve_cnt <= 0.
  - Otherwise, when dsp_req loses to the CPU: starve_cnt <= starve_cnt+1, saturating at STARVE_MAX.
- Latency:
  - CPU has zero added latency when granted.
  - Display data arrives exactly 1 cycle after dsp_gnt.
  - Worst-case display wait under continuous CPU traffic is STARVE_MAX+1 cycles.
- Boundaries:
  - The forced grant lasts exactly one cycle. The counter then restarts at 0, so the CPU wins the next STARVE_MAX contended cycles.
  - A back-to-back dsp_req immediately after a grant is legal; it is a new request.
  - A CPU write stalled by a forced grant is not written. The CPU re-presents it next cycle, and the memory sees exactly one write.
  - If dsp_req drops without a grant (protocol violation), the counter clears and no gnt or valid is issued.
  - Reset asserted the cycle after dsp_gnt: dsp_valid=0 and dsp_rdata=0 at the next edge; the pending valid is discarded.

Decomposition:
- Shared package arb_defs:
  - Owner encoding: OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DSP=2'd2.
  - STARVE_MAX default constant.
- One natural sub-module: starve_counter. It is a saturating counter with clr and inc inputs and an at_max output; the mux and data registers stay in dmem_arbiter.

Test Plan:
- Reset: hold reset with cpu_memwrite=1, dsp_req=1 -> mem_memwrite=0, dsp_gnt=0, cpu_stall=0, dsp_rdata=0.
- CPU only: cpu_memwrite=1, cpu_adr=0x10, cpu_writedata=0xDEADBEEF, one cycle; then cpu_memread at 0x10 -> cpu_memdata=0xDEADBEEF in the read cycle, cpu_stall=0.
- Display only: preload mem[0x20]=0x5; dsp_req with dsp_adr=0x20 -> dsp_gnt in the same cycle, dsp_valid next cycle, dsp_rdata=0x5.
- Starvation (STARVE_MAX=4): continuous cpu_memread plus dsp_req -> CPU granted cycles 0-3, dsp_gnt and cpu_stall in cycle 4, CPU regains the port in cycle 5.
- Stalled write: cpu_memwrite 0x77 to 0x30 held across the forced grant -> mem_memwrite low in the stall cycle, exactly one write to 0x30, mem[0x30]=0x77.
- Reset mid-transfer: assert reset the cycle after dsp_gnt -> dsp_valid=0, starve_cnt=0, and the first post-reset contended cycle grants the CPU.
